// File: rtl/rf_dump_ctrl.sv
// Purpose: halts the core and streams x[first]..x[last] from the register file read port.
// Latency: one cycle from start to halt_req, then 2 cycles per word (READ + SEND) once halt_ack is seen.
// Backpressure: out_data/out_idx/out_last hold in SEND until out_ready; out_valid is decoded from state only.
module rf_dump_ctrl #(
  parameter int NUM_REGS     = 32,
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter bit ZERO_X0      = 1'b1,
  parameter int HALT_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_idx,
  input  logic [ADDR_W-1:0] last_idx,
  input  logic              abort,
  output logic              halt_req,
  input  logic              halt_ack,
  output logic [ADDR_W-1:0] rs_addr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int TW = $clog2(HALT_TIMEOUT + 1);
  localparam logic [ADDR_W:0] LAST_OK = (ADDR_W + 1)'(NUM_REGS - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(HALT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HALT = 3'd1,
    S_READ = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_idx_q, cur_idx_d;
  logic [ADDR_W-1:0] end_idx_q, end_idx_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_idx_q, out_idx_d;
  logic              out_last_q, out_last_d;
  logic              err_q, err_d;
  logic              range_bad;

  // A range is rejected when it runs backwards or past the last architectural register,
  // which also guarantees cur_idx never has to wrap.
  assign range_bad = (first_idx > last_idx) || ({1'b0, last_idx} > LAST_OK);

  // Next-state logic: abort outranks handshake/timeout in every active state.
  always_comb begin
    state_d    = state_q;
    cur_idx_d  = cur_idx_q;
    end_idx_d  = end_idx_q;
    tmo_d      = tmo_q;
    out_data_d = out_data_q;
    out_idx_d  = out_idx_q;
    out_last_d = out_last_q;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_idx_d = first_idx;
          end_idx_d = last_idx;
          if (range_bad) begin
            err_d = 1'b1;
          end else begin
            tmo_d   = '0;
            state_d = S_HALT;
          end
        end
      end
      S_HALT: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (halt_ack) begin
          state_d = S_READ;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_READ: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          out_data_d = (ZERO_X0 && (cur_idx_q == '0)) ? '0 : rf_rdata;
          out_idx_d  = cur_idx_q;
          out_last_d = (cur_idx_q == end_idx_q);
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (out_ready) begin
          if (out_last_q) begin
            state_d = S_DONE;
          end else begin
            cur_idx_d = cur_idx_q + 1'b1;
            state_d   = S_READ;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset clearing everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cur_idx_q  <= '0;
      end_idx_q  <= '0;
      tmo_q      <= '0;
      out_data_q <= '0;
      out_idx_q  <= '0;
      out_last_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_idx_q  <= cur_idx_d;
      end_idx_q  <= end_idx_d;
      tmo_q      <= tmo_d;
      out_data_q <= out_data_d;
      out_idx_q  <= out_idx_d;
      out_last_q <= out_last_d;
      err_q      <= err_d;
    end
  end

  assign halt_req  = (state_q == S_HALT) || (state_q == S_READ) || (state_q == S_SEND);
  assign rs_addr   = (state_q == S_READ) ? cur_idx_q : '0;
  assign out_valid = (state_q == S_SEND);
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_rf_dump_ctrl.sv
// Purpose: directed and randomized dumps of rf_dump_ctrl against a queue-based word model.
// Latency: inputs driven 1 time unit after each rising edge, outputs observed there too.
// Backpressure: out_ready is held high, patterned 1-0-0-1, or randomized per cycle.
module tb_rf_dump_ctrl;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int HT       = 255;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              halt_ack = 1'b0;
  logic              out_ready = 1'b0;
  logic [ADDR_W-1:0] first_idx = '0;
  logic [ADDR_W-1:0] last_idx = '0;
  logic              halt_req, out_valid, out_last, busy, done, err;
  logic [ADDR_W-1:0] rs_addr, out_idx;
  logic [DATA_W-1:0] rf_rdata, out_data;
  logic [DATA_W-1:0] regs [NUM_REGS];
  int checks = 0;
  int errors = 0;

  rf_dump_ctrl #(
    .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ZERO_X0(1'b1), .HALT_TIMEOUT(HT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .first_idx(first_idx), .last_idx(last_idx),
    .abort(abort), .halt_req(halt_req), .halt_ack(halt_ack), .rs_addr(rs_addr),
    .rf_rdata(rf_rdata), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done), .err(err)
  );

  assign rf_rdata = regs[rs_addr];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_halt"}, halt_req, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // Drives one complete dump and checks every accepted word against the expected list.
  task automatic run_dump(input int f, input int l, input int rmode, input int ack_dly);
    logic [DATA_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] idx_q[$];
    bit                pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int                hcnt = 0;
    int                hr_cyc = 0;
    int                cyc = 0;
    int                pc = 0;
    bit                fin = 1'b0;
    bit                prev_stall = 1'b0;
    bit                rdy;
    logic [DATA_W-1:0] hd = '0;
    logic [ADDR_W-1:0] hi = '0;
    logic              hl = 1'b0;
    int                nwords = l - f + 1;
    for (int i = f; i <= l; i++) begin
      exp_q.push_back((i == 0) ? '0 : regs[i]);
      idx_q.push_back(ADDR_W'(i));
    end
    first_idx = ADDR_W'(f);
    last_idx  = ADDR_W'(l);
    start     = 1'b1;
    halt_ack  = 1'b0;
    out_ready = 1'b0;
    step();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_halt", halt_req, 1);
    while (!fin && cyc < 3000) begin
      cyc++;
      if (halt_req) begin
        hr_cyc++;
        hcnt++;
      end
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, hd);
        chk("stall_idx", out_idx, hi);
        chk("stall_last", out_last, hl);
      end
      if (done) begin
        chk("done_halt_low", halt_req, 0);
        chk("done_words_left", exp_q.size(), 0);
        fin = 1'b1;
        prev_stall = 1'b0;
      end else if (out_valid) begin
        chk("valid_under_halt", halt_req, 1);
        if (rmode == 0) rdy = 1'b1;
        else if (rmode == 1) rdy = pat[pc % 4];
        else rdy = 1'($urandom_range(0, 1));
        pc++;
        out_ready = rdy;
        if (rdy) begin
          if (exp_q.size() == 0) begin
            chk("extra_word", exp_q.size(), 1);
          end else begin
            chk("word_data", out_data, exp_q[0]);
            chk("word_idx", out_idx, idx_q[0]);
            chk("word_last", out_last, (exp_q.size() == 1));
            void'(exp_q.pop_front());
            void'(idx_q.pop_front());
          end
        end
        prev_stall = !rdy;
        hd = out_data;
        hi = out_idx;
        hl = out_last;
      end else begin
        out_ready  = 1'($urandom_range(0, 1));
        prev_stall = 1'b0;
      end
      halt_ack = (hcnt > ack_dly);
      step();
    end
    chk("dump_finished", fin, 1);
    if (rmode == 0) chk("stream_cycles", hr_cyc, ack_dly + 1 + 2 * nwords);
    halt_ack  = 1'b0;
    out_ready = 1'b0;
    chk("post_done_busy", busy, 0);
    chk("post_done_pulse", done, 0);
    chk("post_done_err", err, 0);
  endtask

  initial begin
    int  cnt;
    bit  seen_valid;
    bit  found;
    int  f;
    int  l;

    regs[0] = 32'hDEADBEEF;
    for (int n = 1; n < NUM_REGS; n++) regs[n] = DATA_W'(n * 32'h11);

    // Reset state.
    rst_n = 1'b0;
    step();
    step();
    chk_quiet("reset");
    chk("reset_err", err, 0);
    chk("reset_data", out_data, 0);
    chk("reset_idx", out_idx, 0);
    chk("reset_last", out_last, 0);
    chk("reset_rs_addr", rs_addr, 0);
    rst_n = 1'b1;
    step();

    // Full dump, always ready, ack right away; x0 must read as zero.
    run_dump(0, 31, 0, 0);

    // Short dump under a 1-0-0-1 ready pattern.
    run_dump(5, 7, 1, 0);

    // Backwards range: error pulse only, core never halted.
    first_idx = 5'd9;
    last_idx  = 5'd3;
    start     = 1'b1;
    step();
    start = 1'b0;
    chk("range_err", err, 1);
    chk_quiet("range_pulse");
    step();
    chk("range_err_drop", err, 0);
    chk_quiet("range_after");

    // Halt timeout with halt_ack stuck low.
    first_idx  = 5'd2;
    last_idx   = 5'd6;
    start      = 1'b1;
    step();
    start      = 1'b0;
    cnt        = 0;
    seen_valid = 1'b0;
    while (halt_req && cnt < 400) begin
      cnt++;
      if (out_valid) seen_valid = 1'b1;
      step();
    end
    chk("timeout_cycles", cnt, HT);
    chk("timeout_no_valid", seen_valid, 0);
    chk("timeout_err", err, 1);
    chk_quiet("timeout");
    step();
    chk("timeout_err_drop", err, 0);

    // Abort while the second word is being offered; ready stays high to test priority.
    first_idx = 5'd0;
    last_idx  = 5'd4;
    start     = 1'b1;
    halt_ack  = 1'b1;
    out_ready = 1'b1;
    step();
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (out_valid && out_idx == 5'd1) found = 1'b1;
      else step();
    end
    chk("abort_reached", found, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    halt_ack = 1'b0;
    out_ready = 1'b0;
    chk("abort_err", err, 1);
    chk_quiet("abort");
    step();
    chk("abort_err_drop", err, 0);
    chk("abort_no_done", done, 0);
    run_dump(0, 4, 1, 0);

    // Reset for one edge in the middle of a dump.
    first_idx = 5'd0;
    last_idx  = 5'd31;
    start     = 1'b1;
    halt_ack  = 1'b1;
    out_ready = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 9; c++) step();
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    step();
    rst_n     = 1'b1;
    halt_ack  = 1'b0;
    out_ready = 1'b0;
    chk_quiet("midreset");
    chk("midreset_err", err, 0);
    chk("midreset_data", out_data, 0);
    chk("midreset_idx", out_idx, 0);
    chk("midreset_last", out_last, 0);
    chk("midreset_rs_addr", rs_addr, 0);
    step();
    regs[3] = $urandom;
    run_dump(3, 3, 0, 0);

    // Randomized register contents, ranges, ack delays and backpressure.
    for (int t = 0; t < 6; t++) begin
      for (int n = 0; n < NUM_REGS; n++) regs[n] = $urandom;
      f = $urandom_range(0, 31);
      l = $urandom_range(f, 31);
      run_dump(f, l, (t % 2 == 0) ? 2 : 0, $urandom_range(0, 3));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_dump_ctrl.md
Name: rf_dump_ctrl

Overview:
Debug read-out engine for the integer register file. On request it halts the core, then walks a range of architectural registers x[first]..x[last] through the register file's asynchronous read port. It streams each value out on a valid/ready interface and then releases the core. It is the reader counterpart to the writeback path, used by the debug/trace logic alongside the single-cycle core.

Parameters:
NUM_REGS, 32, number of architectural registers
ADDR_W, 5, register index width (log2 NUM_REGS)
DATA_W, 32, register data width
ZERO_X0, 1, when 1 the entry for index 0 is reported as 0 regardless of storage contents
HALT_TIMEOUT, 255, max cycles to wait for halt_ack before aborting with error

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  dump request, sampled only in IDLE
first_idx  input  ADDR_W  first register index, latched on accepted start
last_idx  input  ADDR_W  last register index, latched on accepted start
abort  input  1  cancel the dump in progress
halt_req  output  1  request the core to freeze (no rf_en and no rs1 use by decode)
halt_ack  input  1  core is frozen
rs_addr  output  ADDR_W  read index driven to the register file rs1 port
rf_rdata  input  DATA_W  register file rdata1 (combinational from rs_addr)
out_valid  output  1  stream word valid
out_ready  input  1  stream consumer ready
out_data  output  DATA_W  register value
out_idx  output  ADDR_W  register index of out_data
out_last  output  1  marks the final word of the dump
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on normal completion
err  output  1  one-cycle pulse on range error, halt timeout, or abort

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE, and every output and internal register is set to 0. This applies in any state; a dump in progress is dropped without done or err.
- States: IDLE, HALT, READ, SEND, DONE.
- IDLE: start=1 latches first_idx/last_idx into cur_idx/end_idx.
  - If first_idx > last_idx: err pulses next cycle, state stays IDLE, halt_req is never raised.
  - Otherwise the next state is HALT.
- HALT: halt_req=1 and the timeout counter increments each cycle.
  - halt_ack=1 sampled -> READ.
  - Counter reaching HALT_TIMEOUT without halt_ack -> IDLE with an err pulse and halt_req low.
- READ (one cycle): rs_addr=cur_idx. At the clock edge out_data <= rf_rdata, or 0 if ZERO_X0=1 and cur_idx==0. Also out_idx <= cur_idx and out_last <= (cur_idx==end_idx). Then -> SEND.
- SEND: out_valid=1. out_data, out_idx and out_last stay stable until the handshake.
  - out_valid & out_ready: out_valid drops next cycle.
  - If out_last: -> DONE. Otherwise cur_idx+1 and -> READ.
  - Throughput is 1 word per 2 cycles with out_ready held high.
- DONE (one cycle): done=1 and halt_req=0 -> IDLE.
- halt_req stays 1 in HALT, READ and SEND. It drops in the cycle DONE or IDLE is entered.
- abort=1 in HALT, READ or SEND: next state IDLE, out_valid=0, halt_req=0, err pulse, done not pulsed. abort is ignored in IDLE and DONE.
- Priority: rst_n > abort > handshake or timeout.
- rs_addr=0 outside READ. The index never wraps because end_idx ≤ NUM_REGS-1 is enforced by the range check.
- start outside IDLE is ignored. halt_ack falling during READ or SEND is ignored, because the core must hold while halt_req=1.
- No combinational path from out_ready to out_valid.

Test Plan:
- first=0, last=31, halt_ack one cycle after halt_req, out_ready=1, x0 storage=0xDEADBEEF, xN=N*0x11 -> 32 words with idx 0..31, word0=0, out_last only on idx31, done pulse, 64 stream cycles, halt_req low after.
- first=5, last=7, out_ready toggling 1-0-0-1 -> words for x5, x6, x7 in order, data and idx stable while stalled, no duplicates or drops.
- first=9, last=3, start -> err pulse next cycle, halt_req never high, busy stays 0.
- halt_ack tied 0, HALT_TIMEOUT=255 -> err pulse after 255 HALT cycles, back to IDLE, no out_valid.
- abort during SEND of the 2nd word (first=0, last=4) -> out_valid and halt_req low next cycle, err pulse, no done. A later start runs normally.
- rst_n low for one edge mid-dump -> all outputs 0 next cycle. A subsequent dump of x3 only returns a single word with out_last=1.
